// File: rtl/serial_frame_rx.sv
// ---------------------------------------------------------------------------
// serial_frame_rx
//
// Framed serial receiver fed one bit per enabled clock by an upstream
// parallel-in/serial-out shifter. Frame format, first bit first:
//   start (1), DATA_W data bits MSB first, even parity (if PARITY_EN), stop (0)
// Good words are presented on a valid/ready port. Bad frames are dropped and
// flagged with a one-cycle pulse. Good words that find the output slot still
// held are dropped and recorded in a sticky overrun flag.
//
// Parameters
//   DATA_W     data bits per frame (2..16)
//   PARITY_EN  1 = even-parity bit follows the data, 0 = no parity bit
// Ports
//   clk         clock, rising edge
//   reset       asynchronous, active-high reset
//   s_in        serial bit stream (idle level 0)
//   bit_en      bit strobe; s_in is only sampled on edges with bit_en=1
//   ovr_clr     synchronous clear of the sticky overrun flag
//   out_data    received word, stable while out_valid=1
//   out_valid   word available
//   out_ready   consumer accepts the word on an edge with out_valid&out_ready
//   parity_err  one-cycle pulse: parity mismatch, frame dropped
//   frame_err   one-cycle pulse: stop bit not 0, frame dropped
//   overrun     sticky: good frame lost because the output was held
//   busy        receiver is inside a frame (not IDLE)
// ---------------------------------------------------------------------------
module serial_frame_rx #(
    parameter int DATA_W    = 8,
    parameter int PARITY_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_in,
    input  logic              bit_en,
    input  logic              ovr_clr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);

    localparam int               CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              par_q,   par_d;
    logic              stop_eval;

    // Frame evaluation on the STOP edge
    logic par_ok;
    logic good;
    logic slot_free;
    logic load;
    logic ovr_set;
    logic perr_set;
    logic ferr_set;

    // -----------------------------------------------------------------------
    // FSM state register (also holds the bit counter, shifter, parity bit)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic; everything holds when bit_en=0
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        stop_eval = 1'b0;
        if (bit_en) begin
            case (state_q)
                IDLE: begin
                    if (s_in) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end
                end
                DATA: begin
                    shreg_d = {shreg_q[DATA_W-2:0], s_in};
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT)
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                end
                PARITY: begin
                    par_d   = s_in;
                    state_d = STOP;
                end
                STOP: begin
                    // s_in is the stop bit on this edge
                    stop_eval = 1'b1;
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Frame check. Framing error outranks parity error; only a frame that
    // passes both is a candidate for delivery.
    // -----------------------------------------------------------------------
    assign par_ok    = (PARITY_EN == 0) || !(^{shreg_q, par_q});
    assign ferr_set  = stop_eval &&  s_in;
    assign perr_set  = stop_eval && !s_in && !par_ok;
    assign good      = stop_eval && !s_in &&  par_ok;
    // Slot counts as free if it is empty or being consumed on this edge
    assign slot_free = !out_valid || out_ready;
    assign load      = good &&  slot_free;
    assign ovr_set   = good && !slot_free;

    // -----------------------------------------------------------------------
    // Output port, error pulses and sticky overrun run every clock,
    // independent of bit_en.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            parity_err <= perr_set;
            frame_err  <= ferr_set;

            // A load on the same edge as a consume keeps valid high
            if (load) begin
                out_data  <= shreg_q;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            // Set wins over a coincident clear
            if (ovr_set)
                overrun <= 1'b1;
            else if (ovr_clr)
                overrun <= 1'b0;
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
module tb_serial_frame_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       s_in;
    logic       bit_en;
    logic       ovr_clr;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int errors = 0;

    serial_frame_rx #(.DATA_W(8), .PARITY_EN(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .s_in       (s_in),
        .bit_en     (bit_en),
        .ovr_clr    (ovr_clr),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic       e_valid;
        logic [7:0] e_data;
        logic       e_perr;
        logic       e_ferr;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Advance one clock; return 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        s_in   = b;
        bit_en = 1'b1;
        tick();
    endtask

    // Sends start, 8 data bits MSB first, parity, stop. out_ready is set to
    // rdy_stop just before the stop edge. Returns just after the stop edge.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input logic rdy_stop);
        send_bit(1'b1);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        send_bit(p);
        out_ready = rdy_stop;
        send_bit(s);
        bit_en = 1'b0;
        s_in   = 1'b0;
    endtask

    task automatic send_bit_gated(input logic b);
        s_in   = b;
        bit_en = 1'b1;
        tick();
        s_in   = ~b;     // must be ignored while bit_en=0
        bit_en = 1'b0;
        tick();
    endtask

    initial begin
        logic [10:0] fr;

        //        data   par  stop valid e_data perr ferr
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0};
        vecs[2] = '{8'h81, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1};
        vecs[3] = '{8'h81, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1};
        vecs[4] = '{8'h01, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[5] = '{8'hFE, 1'b1, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[6] = '{8'h01, 1'b0, 1'b0, 1'b0, 8'hFE, 1'b1, 1'b0};

        reset = 1'b1; s_in = 1'b0; bit_en = 1'b0; ovr_clr = 1'b0; out_ready = 1'b0;
        tick(); tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_perr", parity_err, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        tick();

        // Table-driven frames, consumer always ready
        for (int i = 0; i < 7; i++) begin
            out_ready = 1'b1;
            send_frame(vecs[i].data, vecs[i].par, vecs[i].stop, 1'b1);
            chk($sformatf("v%0d_valid", i), out_valid, vecs[i].e_valid);
            chk($sformatf("v%0d_data", i), out_data, vecs[i].e_data);
            chk($sformatf("v%0d_perr", i), parity_err, vecs[i].e_perr);
            chk($sformatf("v%0d_ferr", i), frame_err, vecs[i].e_ferr);
            chk($sformatf("v%0d_busy", i), busy, 0);
            tick();
            chk($sformatf("v%0d_valid_next", i), out_valid, 0);
            chk($sformatf("v%0d_perr_next", i), parity_err, 0);
            chk($sformatf("v%0d_ferr_next", i), frame_err, 0);
            chk($sformatf("v%0d_data_next", i), out_data, vecs[i].e_data);
        end

        // Overrun: two good frames back-to-back with consumer stalled
        out_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b0, 1'b0);
        chk("ovr_first_valid", out_valid, 1);
        chk("ovr_first_data", out_data, 8'h11);
        send_frame(8'h22, 1'b0, 1'b0, 1'b0);
        chk("ovr_data_held", out_data, 8'h11);
        chk("ovr_valid_held", out_valid, 1);
        chk("ovr_set", overrun, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("ovr_consumed", out_valid, 0);
        chk("ovr_sticky", overrun, 1);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        chk("ovr_cleared", overrun, 0);

        // Simultaneous load and consume
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        chk("sim_first_data", out_data, 8'h55);
        send_frame(8'h66, 1'b0, 1'b0, 1'b1);
        chk("sim_valid", out_valid, 1);
        chk("sim_data", out_data, 8'h66);
        chk("sim_ovr", overrun, 0);
        tick();             // out_ready still 1: consumes 0x66
        chk("sim_consumed", out_valid, 0);
        out_ready = 1'b0;

        // bit_en gating: 0xC3, parity 0, stop 0
        fr = {1'b1, 8'hC3, 1'b0, 1'b0};
        for (int i = 10; i >= 1; i--) send_bit_gated(fr[i]);
        chk("gate_busy", busy, 1);
        chk("gate_not_yet", out_valid, 0);
        send_bit_gated(fr[0]);
        chk("gate_valid", out_valid, 1);
        chk("gate_data", out_data, 8'hC3);
        chk("gate_busy_done", busy, 0);

        // Reset mid-frame with 0xC3 still held
        send_bit(1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        chk("mid_busy", busy, 1);
        reset = 1'b1;
        #2;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ovr", overrun, 0);
        chk("mid_rst_errs", {parity_err, frame_err}, 0);
        reset = 1'b0;
        bit_en = 1'b0;
        tick();
        out_ready = 1'b1;
        send_frame(8'h0F, 1'b0, 1'b0, 1'b1);
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_data", out_data, 8'h0F);
        chk("post_rst_errs", {parity_err, frame_err}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
